// File: rtl/fl_first_extract.sv
// FrameLink first-word extractor: strips each frame's header word into a side register and
// forwards the rest as a well-formed frame. FL_FIRST_EXTRACT_CNT_EN builds frame/short counters.
module fl_first_extract #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DREM_WIDTH = (DATA_WIDTH <= 16) ? 1 : $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [DREM_WIDTH-1:0] rx_rem,
    input  logic                  rx_sof_n,
    input  logic                  rx_eof_n,
    input  logic                  rx_sop_n,
    input  logic                  rx_eop_n,
    input  logic                  rx_src_rdy_n,
    output logic                  rx_dst_rdy_n,

    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [DREM_WIDTH-1:0] tx_rem,
    output logic                  tx_sof_n,
    output logic                  tx_eof_n,
    output logic                  tx_sop_n,
    output logic                  tx_eop_n,
    output logic                  tx_src_rdy_n,
    input  logic                  tx_dst_rdy_n,

    output logic [DATA_WIDTH-1:0] extract_data,
    output logic [DREM_WIDTH-1:0] extract_rem,
    output logic                  extract_vld,
    input  logic                  extract_read,

    output logic [31:0]           frame_cnt,
    output logic [31:0]           short_cnt
);

    typedef enum logic [1:0] {S_HDR, S_FIRST, S_BODY} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] extract_data_q;
    logic [DREM_WIDTH-1:0] extract_rem_q;
    logic                  extract_vld_q;
    logic                  hdr_load;

    always_comb begin
        tx_data      = rx_data;
        tx_rem       = rx_rem;
        tx_sof_n     = rx_sof_n;
        tx_eof_n     = rx_eof_n;
        tx_sop_n     = rx_sop_n;
        tx_eop_n     = rx_eop_n;
        tx_src_rdy_n = 1'b1;
        rx_dst_rdy_n = 1'b1;
        state_d      = state_q;
        hdr_load     = 1'b0;
        // Handshakes stay closed for the whole time reset is high.
        if (!reset) begin
            unique case (state_q)
                S_HDR: begin
                    // A read in this cycle frees the slot for an incoming header.
                    rx_dst_rdy_n = extract_vld_q & ~extract_read;
                    if (!rx_src_rdy_n && !rx_dst_rdy_n) begin
                        hdr_load = 1'b1;
                        state_d  = rx_eof_n ? S_FIRST : S_HDR;
                    end
                end
                S_FIRST: begin
                    tx_src_rdy_n = rx_src_rdy_n;
                    rx_dst_rdy_n = tx_dst_rdy_n;
                    tx_sof_n     = 1'b0;
                    tx_sop_n     = 1'b0;
                    if (!rx_src_rdy_n && !tx_dst_rdy_n) begin
                        state_d = rx_eof_n ? S_BODY : S_HDR;
                    end
                end
                S_BODY: begin
                    tx_src_rdy_n = rx_src_rdy_n;
                    rx_dst_rdy_n = tx_dst_rdy_n;
                    tx_sof_n     = 1'b1;
                    if (!rx_src_rdy_n && !tx_dst_rdy_n && !rx_eof_n) begin
                        state_d = S_HDR;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // A header load takes priority over a read-clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            extract_data_q <= '0;
            extract_rem_q  <= '0;
            extract_vld_q  <= 1'b0;
        end else if (hdr_load) begin
            extract_data_q <= rx_data;
            extract_rem_q  <= rx_rem;
            extract_vld_q  <= 1'b1;
        end else if (extract_read && extract_vld_q) begin
            extract_vld_q  <= 1'b0;
        end
    end

    assign extract_data = extract_data_q;
    assign extract_rem  = extract_rem_q;
    assign extract_vld  = extract_vld_q;

`ifdef FL_FIRST_EXTRACT_CNT_EN
    logic [31:0] frame_cnt_q;
    logic [31:0] short_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            short_cnt_q <= '0;
        end else if (hdr_load) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            if (!rx_eof_n) begin
                short_cnt_q <= short_cnt_q + 32'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign short_cnt = short_cnt_q;
`else
    assign frame_cnt = '0;
    assign short_cnt = '0;
`endif

endmodule

// File: doc/fl_first_extract.md
Name: fl_first_extract

Overview:
- FrameLink stage that sits directly downstream of the first-word insert stage.
- Strips the first word (header) of every frame and presents it on a side register with a valid/read handshake.
- Forwards the remaining words as a well-formed FrameLink frame, with SOF_N and SOP_N moved to the new first word.
- Applies backpressure when the side register is still occupied at the next header.

Parameters:
DATA_WIDTH, 32, FrameLink data width in bits; allowed values 8, 16, 32, 64, 128.
DREM_WIDTH, log2(DATA_WIDTH/8) (min 1), width of the DREM field.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
RX_DATA  in  DATA_WIDTH  input frame data
RX_REM  in  DREM_WIDTH  valid bytes minus 1 on the EOP word
RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  1 each  frame/part delimiters, active low
RX_SRC_RDY_N  in  1  upstream data valid, active low
RX_DST_RDY_N  out  1  this block ready, active low
TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N  out  as RX  output frame
TX_DST_RDY_N  in  1  downstream ready, active low
EXTRACT_DATA  out  DATA_WIDTH  last extracted header word
EXTRACT_REM  out  DREM_WIDTH  RX_REM captured with the header
EXTRACT_VLD  out  1  header register occupied
EXTRACT_READ  in  1  consumer takes header; honoured only when EXTRACT_VLD=1
FRAME_CNT  out  32  extracted-header count (optional feature)
SHORT_CNT  out  32  single-word-frame count (optional feature)

Behaviour:
- Transfer on RX when RX_SRC_RDY_N=0 and RX_DST_RDY_N=0; on TX when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
- Reset (async): FSM to S_HDR, EXTRACT_VLD=0, EXTRACT_DATA=0, EXTRACT_REM=0, counters=0.
- While RESET=1: RX_DST_RDY_N=1 and TX_SRC_RDY_N=1, forced.
- FSM states: S_HDR (next RX word is a header), S_FIRST (next word opens the forwarded frame), S_BODY (pass-through).
- S_HDR:
  - TX_SRC_RDY_N=1.
  - RX_DST_RDY_N = EXTRACT_VLD and not EXTRACT_READ, so a read in the same cycle frees the slot.
  - On transfer: EXTRACT_DATA/EXTRACT_REM load RX_DATA/RX_REM; EXTRACT_VLD=1 from the next cycle.
  - If RX_EOF_N=0 (single-word frame): remain in S_HDR; nothing is emitted on TX.
  - Otherwise go to S_FIRST.
  - The RX_SOF_N value is not checked; any word accepted in S_HDR is the header.
- S_FIRST:
  - Combinational pass-through: TX_DATA=RX_DATA, TX_REM=RX_REM, TX_SRC_RDY_N=RX_SRC_RDY_N, RX_DST_RDY_N=TX_DST_RDY_N.
  - TX_SOF_N=0 and TX_SOP_N=0 forced; TX_EOF_N and TX_EOP_N passed through.
  - On transfer: RX_EOF_N=0 goes to S_HDR, else to S_BODY.
- S_BODY:
  - Full pass-through of all signals.
  - TX_SOF_N=1 forced.
  - On transfer with RX_EOF_N=0, go to S_HDR.
- EXTRACT_VLD clears the cycle after EXTRACT_READ=1 unless a new header loads in the same cycle; load wins, and VLD stays 1 with the new data.
- EXTRACT_READ while EXTRACT_VLD=0 is ignored.
- TX path latency is 0 cycles, combinational. Header capture latency is 1 cycle.
- No words are created or reordered. TX word count per frame = RX word count - 1.
- Reset mid-frame: the current partial frame is discarded and the next accepted word is treated as a header. Downstream must be reset together.

Optional Feature:
- Macro FL_FIRST_EXTRACT_CNT_EN.
- Defined:
  - FRAME_CNT increments on every header transfer.
  - SHORT_CNT increments on every header transfer with RX_EOF_N=0.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0.
- Undefined: no counter logic is built; FRAME_CNT and SHORT_CNT are tied to 0.

Test Plan:
- 4-word frame H,A,B,C, DATA_WIDTH=32, EXTRACT_READ held 1 -> EXTRACT_DATA=H one cycle after accept, EXTRACT_VLD pulses; TX emits A(SOF,SOP),B,C(EOF,EOP,REM preserved); 3 TX words.
- Header as its own part (SOP+EOP on H), then 2-word part A,B -> TX A with SOF_N=0 and SOP_N=0, B with EOF_N=0 and EOP_N=0.
- Single-word frame H1 (SOF+EOF) followed by frame H2,X -> EXTRACT_DATA=H1, no TX activity, then EXTRACT_DATA=H2 and TX single word X (SOF+EOF); SHORT_CNT=1, FRAME_CNT=2 with the macro defined.
- EXTRACT_READ=0 and two back-to-back frames -> second header stalls (RX_DST_RDY_N=1); asserting EXTRACT_READ for 1 cycle accepts H2 in that same cycle, and EXTRACT_VLD stays 1.
- Random TX_DST_RDY_N toggling over 100 random frames (1-16 words) -> TX stream equals RX minus first words; RX_DST_RDY_N mirrors TX_DST_RDY_N outside S_HDR.
- RESET asserted mid-frame after 2 body words -> RX_DST_RDY_N=1, TX_SRC_RDY_N=1, EXTRACT_VLD=0 immediately; after release, the next word is captured as a header.
